// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the memory-access controller state encoding
// and its default stall-counter width.
package cpu_types_pkg;

   localparam int WORD_W       = 32;
   localparam int REG_W        = 5;
   localparam int MEMACC_CNT_W = 16;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic [1:0] {
      MA_IDLE,
      MA_WAIT,
      MA_HOLD
   } memacc_state_t;

endpackage : cpu_types_pkg

// File: rtl/mem_access_ctrl_sat_counter.sv
// Width-parameterised saturating up-counter with enable and synchronous
// active-low reset; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_en && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule : sat_counter

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache access controller: issues the load/store, stalls until
// dhit, latches load data while MEM/WB is frozen, and tracks the halt state.
module mem_access_ctrl
   import cpu_types_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = MEMACC_CNT_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              memren_i,
   input  logic              memwen_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] store_i,
   input  logic              halt_i,
   input  logic              advance_i,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [DATA_W-1:0] dmemaddr,
   output logic [DATA_W-1:0] dmemstore,
   output logic [DATA_W-1:0] dmemload_o,
   output logic              mem_stall,
   output logic              halt_o,
   output logic [CNT_W-1:0]  stall_cnt
);

   memacc_state_t     r_state;
   logic              r_halted;
   logic [DATA_W-1:0] r_hold_data;

   logic w_op;
   logic w_req_ren;
   logic w_req_wen;

   // A simultaneous read and write request is illegal; the write wins.
   assign w_req_wen = memwen_i;
   assign w_req_ren = memren_i & ~memwen_i;
   assign w_op      = (memren_i | memwen_i) & ~r_halted;

   // NOTE: requests are combinational from the EX/MEM inputs so an IDLE hit
   // completes in the same cycle; every output gets a default to avoid latches.
   always_comb begin
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      mem_stall = 1'b0;
      if (nRST) begin
         unique case (r_state)
            MA_IDLE: begin
               dmemREN   = w_op & w_req_ren;
               dmemWEN   = w_op & w_req_wen;
               mem_stall = w_op & ~dhit;
            end
            MA_WAIT: begin
               dmemREN   = w_req_ren;
               dmemWEN   = w_req_wen;
               mem_stall = ~dhit;
            end
            MA_HOLD: begin
               dmemREN   = 1'b0;
               dmemWEN   = 1'b0;
               mem_stall = 1'b0;
            end
            default: begin
               dmemREN   = 1'b0;
               dmemWEN   = 1'b0;
               mem_stall = 1'b0;
            end
         endcase
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state     <= MA_IDLE;
         r_halted    <= 1'b0;
         r_hold_data <= '0;
      end else begin
         if (halt_i && advance_i && !mem_stall) begin
            r_halted <= 1'b1;
         end
         unique case (r_state)
            MA_IDLE: begin
               if (w_op && !dhit) begin
                  r_state <= MA_WAIT;
               end else if (w_op && dhit && !advance_i) begin
                  r_state     <= MA_HOLD;
                  r_hold_data <= dmemload;
               end
            end
            MA_WAIT: begin
               if (dhit) begin
                  if (advance_i) begin
                     r_state <= MA_IDLE;
                  end else begin
                     r_state     <= MA_HOLD;
                     r_hold_data <= dmemload;
                  end
               end
            end
            MA_HOLD: begin
               if (advance_i) begin
                  r_state <= MA_IDLE;
               end
            end
            default: r_state <= MA_IDLE;
         endcase
      end
   end

   assign dmemaddr   = addr_i;
   assign dmemstore  = store_i;
   assign dmemload_o = (r_state == MA_HOLD) ? r_hold_data : dmemload;
   assign halt_o     = r_halted | (halt_i & advance_i);

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .i_clk   (CLK),
      .i_rst_n (nRST),
      .i_en    (mem_stall),
      .o_count (stall_cnt)
   );

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized checks of mem_access_ctrl against constants and a
// transaction-level reference model (outstanding/held access, sticky halt).
module tb_mem_access_ctrl;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              CLK = 1'b0;
   logic              nRST;
   logic              memren_i, memwen_i, halt_i, advance_i, dhit;
   logic [DATA_W-1:0] addr_i, store_i, dmemload;
   logic              dmemREN, dmemWEN, mem_stall, halt_o;
   logic [DATA_W-1:0] dmemaddr, dmemstore, dmemload_o;
   logic [CNT_W-1:0]  stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   mem_access_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .memren_i   (memren_i),
      .memwen_i   (memwen_i),
      .addr_i     (addr_i),
      .store_i    (store_i),
      .halt_i     (halt_i),
      .advance_i  (advance_i),
      .dhit       (dhit),
      .dmemload   (dmemload),
      .dmemREN    (dmemREN),
      .dmemWEN    (dmemWEN),
      .dmemaddr   (dmemaddr),
      .dmemstore  (dmemstore),
      .dmemload_o (dmemload_o),
      .mem_stall  (mem_stall),
      .halt_o     (halt_o),
      .stall_cnt  (stall_cnt)
   );

   task automatic drive(input logic ren, input logic wen, input logic [31:0] a,
                        input logic [31:0] s, input logic h, input logic adv,
                        input logic hit, input logic [31:0] ld);
      memren_i = ren; memwen_i = wen; addr_i = a; store_i = s;
      halt_i = h; advance_i = adv; dhit = hit; dmemload = ld;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      nRST = 1'b0;
      next_cycle();
      next_cycle();
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      drive(1, 0, 32'h10, 0, 0, 0, 0, 32'h77);
      @(negedge CLK);
      n_checks++; if (dmemREN !== 1'b0) begin n_fail++; $display("FAIL reset_ren got=%b exp=0", dmemREN); end
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
      next_cycle();
      nRST = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 32'h1357_9BDF);
      @(negedge CLK);
      n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
      n_checks++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL reset_halt got=%b exp=0", halt_o); end
      n_checks++; if (dmemload_o !== 32'h1357_9BDF) begin n_fail++; $display("FAIL reset_load got=%h exp=13579bdf", dmemload_o); end
   endtask

   task automatic test_load_hit();
      do_reset();
      drive(1, 0, 32'h40, 0, 0, 1, 1, 32'hDEAD_BEEF);
      @(negedge CLK);
      n_checks++; if (dmemREN !== 1'b1 || dmemWEN !== 1'b0) begin n_fail++; $display("FAIL hit_req got=%b%b exp=10", dmemREN, dmemWEN); end
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL hit_stall got=%b exp=0", mem_stall); end
      n_checks++; if (dmemload_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hit_load got=%h exp=deadbeef", dmemload_o); end
      n_checks++; if (dmemaddr !== 32'h40) begin n_fail++; $display("FAIL hit_addr got=%h exp=40", dmemaddr); end
      next_cycle();
      drive(1, 0, 32'h44, 0, 0, 0, 0, 32'h1111_1111);
      @(negedge CLK);
      n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL hit_cnt got=%0d exp=0", stall_cnt); end
      n_checks++; if (dmemload_o !== 32'h1111_1111 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL hit_idle got=%h/%b exp=11111111/1", dmemload_o, mem_stall); end
   endtask

   task automatic test_store_miss();
      do_reset();
      for (int c = 1; c <= 4; c++) begin
         drive(0, 1, 32'h80, 32'h1234_5678, 0, logic'(c == 4), logic'(c == 4), 0);
         @(negedge CLK);
         n_checks++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin n_fail++; $display("FAIL st_req c=%0d got=%b%b exp=01", c, dmemREN, dmemWEN); end
         n_checks++; if (mem_stall !== logic'(c < 4)) begin n_fail++; $display("FAIL st_stall c=%0d got=%b exp=%b", c, mem_stall, c < 4); end
         n_checks++; if (dmemaddr !== 32'h80 || dmemstore !== 32'h1234_5678) begin n_fail++; $display("FAIL st_bus c=%0d got=%h/%h", c, dmemaddr, dmemstore); end
         next_cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      n_checks++; if (stall_cnt !== 4'd3) begin n_fail++; $display("FAIL st_cnt got=%0d exp=3", stall_cnt); end
      n_checks++; if (dmemWEN !== 1'b0) begin n_fail++; $display("FAIL st_done got=%b exp=0", dmemWEN); end
   endtask

   task automatic test_hold();
      logic [CNT_W-1:0] cnt0;
      do_reset();
      cnt0 = '0;
      drive(1, 0, 32'h200, 0, 0, 0, 1, 32'hCAFE_0001);
      @(negedge CLK);
      n_checks++; if (dmemREN !== 1'b1 || dmemload_o !== 32'hCAFE_0001) begin n_fail++; $display("FAIL hold_hit got=%b/%h", dmemREN, dmemload_o); end
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         drive(1, 0, 32'h200, 0, 0, logic'(c == 2), 0, 32'h0);
         @(negedge CLK);
         n_checks++; if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL hold_req c=%0d got=%b%b%b exp=000", c, dmemREN, dmemWEN, mem_stall); end
         n_checks++; if (dmemload_o !== 32'hCAFE_0001) begin n_fail++; $display("FAIL hold_data c=%0d got=%h exp=cafe0001", c, dmemload_o); end
      end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 32'h55);
      @(negedge CLK);
      n_checks++; if (dmemload_o !== 32'h55) begin n_fail++; $display("FAIL hold_exit got=%h exp=55", dmemload_o); end
      n_checks++; if (stall_cnt !== cnt0) begin n_fail++; $display("FAIL hold_cnt got=%0d exp=%0d", stall_cnt, cnt0); end
   endtask

   task automatic test_both();
      do_reset();
      drive(1, 1, 32'h300, 32'hA5A5_A5A5, 0, 1, 1, 0);
      @(negedge CLK);
      n_checks++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin n_fail++; $display("FAIL both got=%b%b exp=01", dmemREN, dmemWEN); end
      next_cycle();
   endtask

   task automatic test_saturation();
      logic [CNT_W-1:0] exp_cnt;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         drive(1, 0, 32'h400, 0, 0, 0, 0, 0);
         @(negedge CLK);
         exp_cnt = (k > 15) ? CNT_MAX : CNT_W'(k);
         n_checks++; if (mem_stall !== 1'b1 || stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat k=%0d got=%b/%0d exp=1/%0d", k, mem_stall, stall_cnt, exp_cnt); end
         next_cycle();
      end
      drive(1, 0, 32'h400, 0, 0, 1, 1, 0);
      @(negedge CLK);
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL sat_done got=%b exp=0", mem_stall); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      n_checks++; if (stall_cnt !== CNT_MAX) begin n_fail++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
   endtask

   task automatic test_halt();
      do_reset();
      drive(0, 0, 0, 0, 1, 1, 0, 0);
      @(negedge CLK);
      n_checks++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL halt_now got=%b exp=1", halt_o); end
      next_cycle();
      drive(1, 0, 32'h500, 0, 0, 0, 0, 0);
      @(negedge CLK);
      n_checks++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL halt_sticky got=%b exp=1", halt_o); end
      n_checks++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL halt_noreq got=%b/%b exp=0/0", dmemREN, mem_stall); end
      next_cycle();
      drive(0, 1, 32'h504, 32'h9, 0, 0, 0, 0);
      @(negedge CLK);
      n_checks++; if (dmemWEN !== 1'b0) begin n_fail++; $display("FAIL halt_nowr got=%b exp=0", dmemWEN); end
   endtask

   task automatic test_reset_mid_miss();
      drive(1, 0, 32'h600, 0, 0, 0, 0, 0);
      for (int c = 0; c < 2; c++) next_cycle();
      nRST = 1'b0;
      @(negedge CLK);
      n_checks++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid got=%b/%b exp=0/0", dmemREN, mem_stall); end
      next_cycle();
      nRST = 1'b1;
      drive(1, 0, 32'h600, 0, 0, 0, 0, 0);
      @(negedge CLK);
      n_checks++; if (stall_cnt !== '0 || halt_o !== 1'b0) begin n_fail++; $display("FAIL rst_after got=%0d/%b exp=0/0", stall_cnt, halt_o); end
      n_checks++; if (dmemREN !== 1'b1 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL rst_reissue got=%b/%b exp=1/1", dmemREN, mem_stall); end
      next_cycle();
   endtask

   // Reference model: an access is either outstanding (issued, awaiting dhit)
   // or held (completed, data parked until the pipeline advances).
   task automatic test_random();
      bit               m_out, m_held, m_halted;
      logic [31:0]      m_data;
      int               m_cnt;
      logic             e_ren, e_wen, e_stall, e_halt;
      logic [31:0]      e_load;
      logic             r_ren, r_wen, busy_req;
      logic [31:0]      r_addr, r_store;
      do_reset();
      m_out = 0; m_held = 0; m_halted = 0; m_data = 0; m_cnt = 0;
      r_ren = 0; r_wen = 0; r_addr = 0; r_store = 0;
      for (int k = 0; k < 400; k++) begin
         if (!(m_out || m_held)) begin
            r_ren   = ($urandom_range(0, 2) == 0);
            r_wen   = ($urandom_range(0, 3) == 0);
            r_addr  = $urandom;
            r_store = $urandom;
         end
         drive(r_ren, r_wen, r_addr, r_store, logic'(k > 350 && $urandom_range(0, 9) == 0),
               logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0), $urandom);
         busy_req = m_out || (!m_held && (r_ren || r_wen) && !m_halted);
         e_ren   = busy_req && r_ren && !r_wen;
         e_wen   = busy_req && r_wen;
         e_stall = busy_req && !dhit;
         e_load  = m_held ? m_data : dmemload;
         e_halt  = m_halted || (halt_i && advance_i);
         @(negedge CLK);
         n_checks++; if (dmemREN !== e_ren || dmemWEN !== e_wen) begin n_fail++; $display("FAIL rnd_req k=%0d got=%b%b exp=%b%b", k, dmemREN, dmemWEN, e_ren, e_wen); end
         n_checks++; if (mem_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall k=%0d got=%b exp=%b", k, mem_stall, e_stall); end
         n_checks++; if (dmemload_o !== e_load) begin n_fail++; $display("FAIL rnd_load k=%0d got=%h exp=%h", k, dmemload_o, e_load); end
         n_checks++; if (halt_o !== e_halt) begin n_fail++; $display("FAIL rnd_halt k=%0d got=%b exp=%b", k, halt_o, e_halt); end
         n_checks++; if (stall_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt k=%0d got=%0d exp=%0d", k, stall_cnt, m_cnt); end
         n_checks++; if (dmemaddr !== r_addr || dmemstore !== r_store) begin n_fail++; $display("FAIL rnd_bus k=%0d", k); end
         if (m_held) begin
            if (advance_i) m_held = 0;
         end else if (busy_req) begin
            if (!dhit) m_out = 1;
            else begin
               m_out = 0;
               if (!advance_i) begin m_held = 1; m_data = dmemload; end
            end
         end
         if (e_stall && m_cnt < 15) m_cnt++;
         if (halt_i && advance_i && !e_stall) m_halted = 1;
         next_cycle();
      end
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      nRST = 1'b0;
      #1;
      test_reset();
      test_load_hit();
      test_store_miss();
      test_hold();
      test_both();
      test_saturation();
      test_halt();
      test_reset_mid_miss();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_access_ctrl
